// File: rtl/spwm_pkg.sv
// spwm_pkg: frame constants, FSM encoding and the byte-select helper shared by the
// SPWM configuration writer and any consumer-side model.
package spwm_pkg;

    localparam int FRAME_BYTES     = 12;
    localparam int PHASE_LIMIT_DEF = 1000;

    typedef enum logic [1:0] {IDLE, WAIT_ROOM, SEND, DONE} state_t;

    typedef struct packed {
        logic [15:0] cycle1;
        logic [15:0] cycle2;
        logic [15:0] cycle3;
        logic [9:0]  phase1;
        logic [9:0]  phase2;
        logic [9:0]  phase3;
    } cfg_t;

    // Each channel occupies four bytes: cycle MSB, cycle LSB, phase MSBs, phase LSB.
    function automatic logic [7:0] frame_byte(input cfg_t f, input logic [3:0] idx);
        logic [15:0] cy;
        logic [9:0]  ph;
        cy = idx[3:2] == 2'd0 ? f.cycle1 : idx[3:2] == 2'd1 ? f.cycle2 : f.cycle3;
        ph = idx[3:2] == 2'd0 ? f.phase1 : idx[3:2] == 2'd1 ? f.phase2 : f.phase3;
        return idx[1:0] == 2'd0 ? cy[15:8] :
               idx[1:0] == 2'd1 ? cy[7:0]  :
               idx[1:0] == 2'd2 ? {6'b0, ph[9:8]} : ph[7:0];
    endfunction

endpackage

// File: rtl/spwm_cfg_writer.sv
// spwm_cfg_writer: serialises a three-channel SPWM config into a 12-byte gap-free FIFO burst.
// Define SPWM_CFG_DEDUP_EN to skip words identical to the last fully written frame.
module spwm_cfg_writer
    import spwm_pkg::*;
#(
    parameter int FIFO_DEPTH  = 256,
    parameter int USEDW_W     = 8,
    parameter int PHASE_LIMIT = PHASE_LIMIT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [15:0]        cfg_cycle1,
    input  logic [15:0]        cfg_cycle2,
    input  logic [15:0]        cfg_cycle3,
    input  logic [9:0]         cfg_phase1,
    input  logic [9:0]         cfg_phase2,
    input  logic [9:0]         cfg_phase3,
    output logic [7:0]         spwm_wrfifo_data,
    output logic               spwm_wrfifo_req,
    input  logic               spwm_wrfifo_full,
    input  logic [USEDW_W-1:0] spwm_wrfifo_usedw,
    output logic               busy,
    output logic               cfg_err,
    output logic [15:0]        frame_cnt
);

    state_t     state;
    logic [3:0] byte_idx;
    cfg_t       sh;
    cfg_t       cfg_in;
    logic       bad;
    logic       room;
    logic       dup;

    assign cfg_in    = {cfg_cycle1, cfg_cycle2, cfg_cycle3, cfg_phase1, cfg_phase2, cfg_phase3};
    assign cfg_ready = state == IDLE;
    assign bad       = int'(cfg_phase1) >= PHASE_LIMIT || int'(cfg_phase2) >= PHASE_LIMIT ||
                       int'(cfg_phase3) >= PHASE_LIMIT;
    // The consumer reads a whole frame without re-checking empty, so wait for full-frame room.
    assign room      = !spwm_wrfifo_full && int'(spwm_wrfifo_usedw) <= FIFO_DEPTH - FRAME_BYTES;

`ifdef SPWM_CFG_DEDUP_EN
    cfg_t last;
    logic last_vld;
    assign dup = last_vld && last == cfg_in;
    always_ff @(posedge clk) begin
        if (reset) begin
            last     <= '0;
            last_vld <= 1'b0;
        end else if (state == DONE) begin
            last     <= sh;
            last_vld <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            byte_idx         <= '0;
            sh               <= '0;
            spwm_wrfifo_data <= '0;
            spwm_wrfifo_req  <= 1'b0;
            cfg_err          <= 1'b0;
            frame_cnt        <= '0;
            busy             <= 1'b0;
        end else begin
            spwm_wrfifo_req <= 1'b0;
            cfg_err         <= 1'b0;
            case (state)
                IDLE: if (cfg_valid) begin
                    if (bad) cfg_err <= 1'b1;
                    else if (!dup) begin
                        sh       <= cfg_in;
                        byte_idx <= '0;
                        state    <= WAIT_ROOM;
                        busy     <= 1'b1;
                    end
                end
                WAIT_ROOM: if (room) begin
                    state            <= SEND;
                    spwm_wrfifo_req  <= 1'b1;
                    spwm_wrfifo_data <= frame_byte(sh, 4'd0);
                    byte_idx         <= 4'd1;
                end
                SEND: if (byte_idx == 4'(FRAME_BYTES)) state <= DONE;
                else begin
                    spwm_wrfifo_req  <= 1'b1;
                    spwm_wrfifo_data <= frame_byte(sh, byte_idx);
                    byte_idx         <= byte_idx + 4'd1;
                end
                DONE: begin
                    frame_cnt <= frame_cnt + 16'd1;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spwm_cfg_writer.sv
// tb_spwm_cfg_writer: directed checks of framing, latency, room wait, rejection, reset and dedup.
module tb_spwm_cfg_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] c1 = '0, c2 = '0, c3 = '0;
    logic [9:0]  p1 = '0, p2 = '0, p3 = '0;
    logic [7:0]  data;
    logic        req;
    logic        full = 1'b0;
    logic [7:0]  usedw = '0;
    logic        busy;
    logic        cfg_err;
    logic [15:0] frame_cnt;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          t;
    logic [7:0]  wq[$];
    int          wc[$];

    localparam logic [95:0] FA = 96'h1234_02A5_ABCD_0064_0001_03E7;
    localparam logic [95:0] FB = 96'h5A5A_0000_0F0F_03E7_C3C3_0155;
    localparam logic [95:0] FC = 96'hFFFF_0000_8001_0100_00FF_00FF;
    localparam logic [95:0] FD = 96'h0102_0003_0304_0205_0607_0308;

    spwm_cfg_writer dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_cycle1(c1), .cfg_cycle2(c2), .cfg_cycle3(c3),
        .cfg_phase1(p1), .cfg_phase2(p2), .cfg_phase3(p3),
        .spwm_wrfifo_data(data), .spwm_wrfifo_req(req), .spwm_wrfifo_full(full),
        .spwm_wrfifo_usedw(usedw), .busy(busy), .cfg_err(cfg_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO write model: records every byte with the edge index that writes it.
    always @(posedge clk) begin
        if (req) begin
            wq.push_back(data);
            wc.push_back(cyc);
            if (full) chk("full_during_send", 32'(full), 32'd0);
        end
        cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [95:0] f);
        {c1, p1, c2, p2, c3, p3} = {f[95:80], f[73:64], f[63:48], f[41:32], f[31:16], f[9:0]};
    endtask

    task automatic clear_q();
        wq.delete();
        wc.delete();
    endtask

    task automatic wait_cnt(input logic [15:0] n, input int lim);
        for (int i = 0; i < lim && frame_cnt != n; i++) tick();
        chk("frame_cnt", 32'(frame_cnt), 32'(n));
    endtask

    task automatic check_frame(input int base, input logic [95:0] f, input int t0);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("byte%0d", base + i), 32'(wq[base+i]), 32'(f[95-8*i -: 8]));
            chk($sformatf("byte%0d_cyc", base + i), 32'(wc[base+i]), 32'(t0 + i));
        end
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // basic frame, byte order and latency
        clear_q();
        set_cfg(FA);
        cfg_valid = 1'b1;
        t = cyc;
        tick();
        cfg_valid = 1'b0;
        chk("acc_ready", 32'(cfg_ready), 32'd0);
        chk("acc_busy", 32'(busy), 32'd1);
        wait_cnt(16'd1, 30);
        chk("done_cycle", 32'(cyc), 32'(t + 15));
        chk("a_ready", 32'(cfg_ready), 32'd1);
        chk("a_busy", 32'(busy), 32'd0);
        chk("a_size", 32'(wq.size()), 32'd12);
        if (wq.size() == 12) check_frame(0, FA, t + 2);

        // room wait: usedw above threshold, then full, then room
        clear_q();
        usedw = 8'd250;
        set_cfg(FB);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        repeat (5) tick();
        chk("wait_req", 32'(req), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        usedw = 8'd245;
        repeat (3) tick();
        chk("wait245_size", 32'(wq.size()), 32'd0);
        usedw = 8'd0;
        full = 1'b1;
        repeat (3) tick();
        chk("waitfull_size", 32'(wq.size()), 32'd0);
        full = 1'b0;
        usedw = 8'd244;
        t = cyc;
        tick();
        chk("room_req", 32'(req), 32'd1);
        wait_cnt(16'd2, 30);
        chk("b_size", 32'(wq.size()), 32'd12);
        if (wq.size() == 12) check_frame(0, FB, t + 1);
        usedw = 8'd0;

        // out-of-range phase rejected
        clear_q();
        set_cfg(FA);
        p2 = 10'd1000;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("err_pulse", 32'(cfg_err), 32'd1);
        chk("err_ready", 32'(cfg_ready), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        tick();
        chk("err_clear", 32'(cfg_err), 32'd0);
        repeat (3) tick();
        chk("err_size", 32'(wq.size()), 32'd0);
        chk("err_cnt", 32'(frame_cnt), 32'd2);

        // valid held across two different words
        clear_q();
        set_cfg(FC);
        cfg_valid = 1'b1;
        t = cyc;
        tick();
        set_cfg(FD);
        for (int i = 0; i < 30 && !cfg_ready; i++) tick();
        chk("second_accept", 32'(cyc), 32'(t + 15));
        tick();
        cfg_valid = 1'b0;
        wait_cnt(16'd4, 30);
        chk("cd_size", 32'(wq.size()), 32'd24);
        if (wq.size() == 24) begin
            check_frame(0, FC, t + 2);
            check_frame(12, FD, t + 17);
        end

        // reset while byte 5 is on the bus
        clear_q();
        set_cfg(FA);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        for (int i = 0; i < 20 && wq.size() < 5; i++) tick();
        chk("mid_req", 32'(req), 32'd1);
        chk("mid_data", 32'(data), 32'hCD);
        reset = 1'b1;
        tick();
        chk("mrst_req", 32'(req), 32'd0);
        chk("mrst_cnt", 32'(frame_cnt), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();
        chk("mrst_ready", 32'(cfg_ready), 32'd1);
        chk("mrst_cnt2", 32'(frame_cnt), 32'd0);

        // identical word sent twice
        clear_q();
        set_cfg(FA);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        wait_cnt(16'd1, 30);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
`ifdef SPWM_CFG_DEDUP_EN
        chk("dup_ready", 32'(cfg_ready), 32'd1);
        repeat (20) tick();
        chk("dup_size", 32'(wq.size()), 32'd12);
        chk("dup_cnt", 32'(frame_cnt), 32'd1);
`else
        chk("dup_ready", 32'(cfg_ready), 32'd0);
        repeat (20) tick();
        chk("dup_size", 32'(wq.size()), 32'd24);
        chk("dup_cnt", 32'(frame_cnt), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
